// File: rtl/sfifo_param_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
// Defaults are reused by the memory-controller FIFO instantiations.
package sfifo_param_pkg;

    localparam int DEF_AFIFODW  = 32;
    localparam int DEF_DEPTHW   = 2;
    localparam int DEF_AFULL_TH = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Pointers carry one extra wrap bit above the storage index.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sfifo_ram_1r1w.sv
// 2**DEPTHW x AFIFODW storage: synchronous write, asynchronous read.
// Kept free of reset so it maps onto distributed RAM.
module sfifo_ram_1r1w #(
    parameter int AFIFODW = 32,
    parameter int DEPTHW  = 2
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [DEPTHW-1:0]  i_waddr,
    input  logic [AFIFODW-1:0] i_wdata,
    input  logic [DEPTHW-1:0]  i_raddr,
    output logic [AFIFODW-1:0] o_rdata
);

    logic [AFIFODW-1:0] r_mem [2**DEPTHW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sfifo_param.sv
// Parametrised first-word-fall-through FIFO: wrap-bit pointers, occupancy,
// almost-full threshold and sticky overflow/underflow flags.
module sfifo_param
    import sfifo_param_pkg::*;
#(
    parameter int AFIFODW  = DEF_AFIFODW,
    parameter int DEPTHW   = DEF_DEPTHW,
    parameter int AFULL_TH = DEF_AFULL_TH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen,
    output logic               wqfull,
    output logic               wqafull,
    input  logic [AFIFODW-1:0] wdata,
    input  logic               rnext,
    output logic               rqempty,
    output logic [AFIFODW-1:0] rdata,
    output logic [DEPTHW:0]    level,
    output logic               err_ovf,
    output logic               err_udf,
    input  logic               err_clr
);

    localparam int PW = ptr_width(2**DEPTHW);
    localparam logic [PW-1:0] AFULL_V = PW'(AFULL_TH);

    if (DEPTHW < 1 || DEPTHW > 10) begin : g_bad_depthw
        $error("sfifo_param: DEPTHW must be in 1..10");
    end
    if (AFULL_TH < 1 || AFULL_TH > 2**DEPTHW) begin : g_bad_afull
        $error("sfifo_param: AFULL_TH must be in 1..2**DEPTHW");
    end
    if (AFIFODW < 1) begin : g_bad_width
        $error("sfifo_param: AFIFODW must be at least 1");
    end

    logic [PW-1:0] r_wadr;
    logic [PW-1:0] r_radr;
    logic          r_err_ovf;
    logic          r_err_udf;

    logic          w_full;
    logic          w_empty;
    logic [PW-1:0] w_level;
    logic          w_wacc;
    logic          w_racc;

    assign w_empty = (r_wadr == r_radr);
    assign w_full  = (r_wadr[DEPTHW-1:0] == r_radr[DEPTHW-1:0]) &&
                     (r_wadr[DEPTHW] != r_radr[DEPTHW]);
    assign w_level = r_wadr - r_radr;
    assign w_wacc  = wen & ~w_full;
    assign w_racc  = rnext & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wadr    <= '0;
            r_radr    <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_wacc) begin
                r_wadr <= r_wadr + PW'(1);
            end
            if (w_racc) begin
                r_radr <= r_radr + PW'(1);
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            r_err_ovf <= (wen & w_full) | (r_err_ovf & ~err_clr);
            r_err_udf <= (rnext & w_empty) | (r_err_udf & ~err_clr);
        end
    end

    // Writes during reset are dropped so reset leaves storage untouched.
    sfifo_ram_1r1w #(
        .AFIFODW (AFIFODW),
        .DEPTHW  (DEPTHW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wacc & ~rst),
        .i_waddr (r_wadr[DEPTHW-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_radr[DEPTHW-1:0]),
        .o_rdata (rdata)
    );

    assign rqempty = w_empty;
    assign wqfull  = w_full;
    assign wqafull = (w_level >= AFULL_V);
    assign level   = w_level;
    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;

endmodule

// File: tb/tb_sfifo_param.sv
// Bench for sfifo_param (DEPTHW=2): queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sfifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int ATH   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wen = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          rnext = 1'b0;
    logic          err_clr = 1'b0;
    logic          wqfull, wqafull, rqempty, err_ovf, err_udf;
    logic [DW-1:0] rdata;
    logic [2:0]    level;

    int checks = 0;
    int errors = 0;

    sfifo_param #(.AFIFODW(DW), .DEPTHW(2), .AFULL_TH(ATH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .wqfull  (wqfull),
        .wqafull (wqafull),
        .wdata   (wdata),
        .rnext   (rnext),
        .rqempty (rqempty),
        .rdata   (rdata),
        .level   (level),
        .err_ovf (err_ovf),
        .err_udf (err_udf),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a queue plus two flags, updated from pre-edge inputs.
    logic [DW-1:0] q[$];
    bit            m_ovf = 0;
    bit            m_udf = 0;
    bit            m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf   = 0;
            m_udf   = 0;
            m_valid = 1;
        end else if (m_valid) begin
            bit full, empty;
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            m_ovf = (wen && full) || (m_ovf && !err_clr);
            m_udf = (rnext && empty) || (m_udf && !err_clr);
            if (rnext && !empty) void'(q.pop_front());
            if (wen && !full) q.push_back(wdata);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_rqempty", DW'(rqempty), DW'(q.size() == 0));
            chk("m_wqfull",  DW'(wqfull),  DW'(q.size() == DEPTH));
            chk("m_wqafull", DW'(wqafull), DW'(q.size() >= ATH));
            chk("m_level",   DW'(level),   DW'(q.size()));
            chk("m_err_ovf", DW'(err_ovf), DW'(m_ovf));
            chk("m_err_udf", DW'(err_udf), DW'(m_udf));
            if (q.size() > 0) chk("m_rdata", rdata, q[0]);
        end
    end

    task automatic cyc(input bit w, input logic [DW-1:0] wd, input bit r,
                       input bit clr, input bit rs);
        wen = w; wdata = wd; rnext = r; err_clr = clr; rst = rs;
        @(posedge clk);
        #2;
        wen = 0; rnext = 0; err_clr = 0; rst = 0;
    endtask

    initial begin
        logic [DW-1:0] fill [4];
        fill[0] = 32'h11; fill[1] = 32'h22; fill[2] = 32'h33; fill[3] = 32'h44;

        // Reset then idle
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("rst_rqempty", DW'(rqempty), 1);
        chk("rst_wqfull",  DW'(wqfull),  0);
        chk("rst_level",   DW'(level),   0);
        chk("rst_ovf",     DW'(err_ovf), 0);
        chk("rst_udf",     DW'(err_udf), 0);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(1, fill[i], 0, 0, 0);
            chk("fill_level",   DW'(level),   DW'(i + 1));
            chk("fill_wqafull", DW'(wqafull), DW'(i + 1 >= 3));
        end
        chk("fill_wqfull", DW'(wqfull), 1);
        cyc(1, 32'h55, 0, 0, 0);
        chk("ovf_level", DW'(level),   4);
        chk("ovf_flag",  DW'(err_ovf), 1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_rdata", rdata, fill[i]);
            cyc(0, 0, 1, 0, 0);
        end
        chk("drain_empty", DW'(rqempty), 1);
        cyc(0, 0, 0, 1, 0);
        chk("ovf_clr", DW'(err_ovf), 0);

        // Streaming across repeated pointer wraps
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i < 20; i++) begin
            chk("stream_rdata", rdata, DW'(i - 1));
            chk("stream_level", DW'(level), 1);
            cyc(1, DW'(i), 1, 0, 0);
        end
        chk("stream_last", rdata, 19);
        cyc(0, 0, 1, 0, 0);
        chk("stream_empty", DW'(rqempty), 1);
        chk("stream_noudf", DW'(err_udf), 0);

        // Underflow with simultaneous write, then clear
        cyc(1, 32'hAA, 1, 0, 0);
        chk("udf_flag",  DW'(err_udf), 1);
        chk("udf_level", DW'(level),   1);
        chk("udf_rdata", rdata,        32'hAA);
        cyc(0, 0, 0, 1, 0);
        chk("udf_clr", DW'(err_udf), 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("udf_set_wins", DW'(err_udf), 1);
        cyc(0, 0, 0, 1, 0);

        // Full with simultaneous write and pop
        for (int i = 0; i < 4; i++) cyc(1, 32'hA0 + DW'(i), 0, 0, 0);
        cyc(1, 32'hBB, 1, 0, 0);
        chk("fullrw_level", DW'(level),   3);
        chk("fullrw_ovf",   DW'(err_ovf), 1);
        chk("fullrw_rdata", rdata,        32'hA1);

        // Reset mid-stream discards entries and the same-cycle write
        cyc(0, 0, 1, 0, 0);
        chk("prerst_level", DW'(level), 2);
        cyc(1, 32'hCC, 1, 0, 1);
        chk("midrst_level", DW'(level),   0);
        chk("midrst_empty", DW'(rqempty), 1);
        chk("midrst_ovf",   DW'(err_ovf), 0);
        cyc(1, 32'hDD, 0, 0, 0);
        chk("postrst_rdata", rdata,       32'hDD);
        chk("postrst_level", DW'(level),  1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 55), $urandom(),
                ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 5),
                ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
